// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs -- ALU reservation station and issue scheduler.
//
// Holds up to ENTRIES dispatched ALU operations. It snoops the ALU and LSU
// result buses to resolve pending source tags. Each cycle it issues the
// lowest-index fully ready operation through registered outputs.
//
// Ports
//   clk, rst, clear       clock, sync active-high reset, misprediction flush
//   disp*                 dispatch request (op, operand values/tags, dest)
//   rsFull                no free slot (from registered busy bits only)
//   aluCdb*, lsCdb*       result broadcast buses (enable, tag, data)
//   ALUworkEn             one-cycle issue strobe
//   operandO/T, opCode,   issued operation fields (these hold their value
//   wrtTag, wrtName,      while nothing is issued)
//   instAddr
// ---------------------------------------------------------------------------
module alu_rs #(
    parameter int ENTRIES = 8,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int NAME_W  = 5,
    parameter int OP_W    = 6,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              dispEn,
    input  logic [OP_W-1:0]   dispOp,
    input  logic [DATA_W-1:0] dispDataO,
    input  logic [DATA_W-1:0] dispDataT,
    input  logic [TAG_W-1:0]  dispTagO,
    input  logic [TAG_W-1:0]  dispTagT,
    input  logic [TAG_W-1:0]  dispWrtTag,
    input  logic [NAME_W-1:0] dispWrtName,
    input  logic [ADDR_W-1:0] dispAddr,
    output logic              rsFull,
    input  logic              aluCdbEn,
    input  logic [TAG_W-1:0]  aluCdbTag,
    input  logic [DATA_W-1:0] aluCdbData,
    input  logic              lsCdbEn,
    input  logic [TAG_W-1:0]  lsCdbTag,
    input  logic [DATA_W-1:0] lsCdbData,
    output logic              ALUworkEn,
    output logic [DATA_W-1:0] operandO,
    output logic [DATA_W-1:0] operandT,
    output logic [OP_W-1:0]   opCode,
    output logic [TAG_W-1:0]  wrtTag,
    output logic [NAME_W-1:0] wrtName,
    output logic [ADDR_W-1:0] instAddr
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Slot storage
    logic [ENTRIES-1:0] busy;
    logic [OP_W-1:0]    slot_op    [ENTRIES];
    logic [DATA_W-1:0]  slot_val_o [ENTRIES];
    logic [DATA_W-1:0]  slot_val_t [ENTRIES];
    logic [TAG_W-1:0]   slot_tag_o [ENTRIES];
    logic [TAG_W-1:0]   slot_tag_t [ENTRIES];
    logic [TAG_W-1:0]   slot_wtag  [ENTRIES];
    logic [NAME_W-1:0]  slot_name  [ENTRIES];
    logic [ADDR_W-1:0]  slot_addr  [ENTRIES];

    logic [ENTRIES-1:0] ready;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               do_alloc;
    logic               flush;

    logic [DATA_W-1:0]  disp_val_o;
    logic [DATA_W-1:0]  disp_val_t;
    logic [TAG_W-1:0]   disp_tag_o;
    logic [TAG_W-1:0]   disp_tag_t;

    assign flush    = rst | clear;
    assign rsFull   = &busy;
    assign do_alloc = dispEn & free_found;

    // Readiness uses registered tags only. A slot woken at an edge becomes
    // ready in the following cycle.
    always_comb begin
        // NOTE: every variable written in always_comb gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        ready = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            ready[i] = busy[i] && (slot_tag_o[i] == '0) && (slot_tag_t[i] == '0);
        end
    end

    // Lowest-index priority encoders for issue select and free-slot allocate.
    always_comb begin
        // NOTE: blocking assignments here on purpose. The found flag must
        // take effect on the next loop iteration within the same evaluation.
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ready[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Dispatch forwarding: a tag that is broadcast in the same cycle is
    // captured immediately. The ALU bus wins over the LSU bus.
    always_comb begin
        disp_val_o = dispDataO;
        disp_tag_o = dispTagO;
        disp_val_t = dispDataT;
        disp_tag_t = dispTagT;
        if (dispTagO != '0) begin
            if (aluCdbEn && aluCdbTag == dispTagO) begin
                disp_val_o = aluCdbData;
                disp_tag_o = '0;
            end else if (lsCdbEn && lsCdbTag == dispTagO) begin
                disp_val_o = lsCdbData;
                disp_tag_o = '0;
            end
        end
        if (dispTagT != '0) begin
            if (aluCdbEn && aluCdbTag == dispTagT) begin
                disp_val_t = aluCdbData;
                disp_tag_t = '0;
            end else if (lsCdbEn && lsCdbTag == dispTagT) begin
                disp_val_t = lsCdbData;
                disp_tag_t = '0;
            end
        end
    end

    // Slot occupancy. The issued slot is always busy and the allocated slot
    // is always free, so the two updates never target the same bit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // flop samples values from before the edge.
        if (flush) begin
            busy <= '0;
        end else begin
            if (sel_found) busy[sel_idx]  <= 1'b0;
            if (do_alloc)  busy[free_idx] <= 1'b1;
        end
    end

    // Slot payload: wakeup, then allocation. Allocation targets a free slot
    // and wakeup only touches busy slots, so the two never collide.
    // NOTE: payload arrays are deliberately not reset. Nothing reads them
    // while busy is clear, and leaving them unreset keeps them plain RAM/flops.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (busy[i]) begin
                if (slot_tag_o[i] != '0) begin
                    if (aluCdbEn && aluCdbTag == slot_tag_o[i]) begin
                        slot_val_o[i] <= aluCdbData;
                        slot_tag_o[i] <= '0;
                    end else if (lsCdbEn && lsCdbTag == slot_tag_o[i]) begin
                        slot_val_o[i] <= lsCdbData;
                        slot_tag_o[i] <= '0;
                    end
                end
                if (slot_tag_t[i] != '0) begin
                    if (aluCdbEn && aluCdbTag == slot_tag_t[i]) begin
                        slot_val_t[i] <= aluCdbData;
                        slot_tag_t[i] <= '0;
                    end else if (lsCdbEn && lsCdbTag == slot_tag_t[i]) begin
                        slot_val_t[i] <= lsCdbData;
                        slot_tag_t[i] <= '0;
                    end
                end
            end
        end
        if (do_alloc) begin
            slot_op[free_idx]    <= dispOp;
            slot_val_o[free_idx] <= disp_val_o;
            slot_val_t[free_idx] <= disp_val_t;
            slot_tag_o[free_idx] <= disp_tag_o;
            slot_tag_t[free_idx] <= disp_tag_t;
            slot_wtag[free_idx]  <= dispWrtTag;
            slot_name[free_idx]  <= dispWrtName;
            slot_addr[free_idx]  <= dispAddr;
        end
    end

    // Issue registers. Fields hold their value when nothing issues.
    always_ff @(posedge clk) begin
        if (flush) begin
            ALUworkEn <= 1'b0;
            operandO  <= '0;
            operandT  <= '0;
            opCode    <= '0;
            wrtTag    <= '0;
            wrtName   <= '0;
            instAddr  <= '0;
        end else begin
            ALUworkEn <= sel_found;
            if (sel_found) begin
                operandO <= slot_val_o[sel_idx];
                operandT <= slot_val_t[sel_idx];
                opCode   <= slot_op[sel_idx];
                wrtTag   <= slot_wtag[sel_idx];
                wrtName  <= slot_name[sel_idx];
                instAddr <= slot_addr[sel_idx];
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// ---------------------------------------------------------------------------
// tb_alu_rs -- self-checking bench for alu_rs.
//
// A slot-level behavioural model advances on every rising edge. A compare
// process checks all DUT outputs against the model on every falling edge.
// Directed scenarios add hand-computed literal checks, and a randomized
// phase follows.
// ---------------------------------------------------------------------------
module tb_alu_rs;

    localparam int ENTRIES = 8;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 4;
    localparam int NAME_W  = 5;
    localparam int OP_W    = 6;
    localparam int ADDR_W  = 32;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              dispEn;
    logic [OP_W-1:0]   dispOp;
    logic [DATA_W-1:0] dispDataO;
    logic [DATA_W-1:0] dispDataT;
    logic [TAG_W-1:0]  dispTagO;
    logic [TAG_W-1:0]  dispTagT;
    logic [TAG_W-1:0]  dispWrtTag;
    logic [NAME_W-1:0] dispWrtName;
    logic [ADDR_W-1:0] dispAddr;
    logic              rsFull;
    logic              aluCdbEn;
    logic [TAG_W-1:0]  aluCdbTag;
    logic [DATA_W-1:0] aluCdbData;
    logic              lsCdbEn;
    logic [TAG_W-1:0]  lsCdbTag;
    logic [DATA_W-1:0] lsCdbData;
    logic              ALUworkEn;
    logic [DATA_W-1:0] operandO;
    logic [DATA_W-1:0] operandT;
    logic [OP_W-1:0]   opCode;
    logic [TAG_W-1:0]  wrtTag;
    logic [NAME_W-1:0] wrtName;
    logic [ADDR_W-1:0] instAddr;

    alu_rs #(
        .ENTRIES(ENTRIES), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .NAME_W(NAME_W), .OP_W(OP_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .dispEn(dispEn), .dispOp(dispOp),
        .dispDataO(dispDataO), .dispDataT(dispDataT),
        .dispTagO(dispTagO), .dispTagT(dispTagT),
        .dispWrtTag(dispWrtTag), .dispWrtName(dispWrtName), .dispAddr(dispAddr),
        .rsFull(rsFull),
        .aluCdbEn(aluCdbEn), .aluCdbTag(aluCdbTag), .aluCdbData(aluCdbData),
        .lsCdbEn(lsCdbEn), .lsCdbTag(lsCdbTag), .lsCdbData(lsCdbData),
        .ALUworkEn(ALUworkEn), .operandO(operandO), .operandT(operandT),
        .opCode(opCode), .wrtTag(wrtTag), .wrtName(wrtName), .instAddr(instAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit                busy;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vo;
        logic [DATA_W-1:0] vt;
        logic [TAG_W-1:0]  to;
        logic [TAG_W-1:0]  tt;
        logic [TAG_W-1:0]  wt;
        logic [NAME_W-1:0] wn;
        logic [ADDR_W-1:0] ad;
    } slot_t;

    slot_t             m_slot [ENTRIES];
    logic              m_work  = 1'b0;
    logic [DATA_W-1:0] m_opo   = '0;
    logic [DATA_W-1:0] m_opt   = '0;
    logic [OP_W-1:0]   m_opc   = '0;
    logic [TAG_W-1:0]  m_wtag  = '0;
    logic [NAME_W-1:0] m_wname = '0;
    logic [ADDR_W-1:0] m_addr  = '0;

    function automatic bit m_full();
        for (int i = 0; i < ENTRIES; i++)
            if (!m_slot[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // Returns 1 and the broadcast value when a valid bus currently carries tag.
    function automatic bit cdb_lookup(input logic [TAG_W-1:0] tag, output logic [DATA_W-1:0] data);
        data = '0;
        if (tag == '0) return 1'b0;
        if (aluCdbEn && aluCdbTag == tag) begin data = aluCdbData; return 1'b1; end
        if (lsCdbEn && lsCdbTag == tag) begin data = lsCdbData; return 1'b1; end
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model
        int sel;
        int fr;
        slot_t ns;
        logic [DATA_W-1:0] d;
        if (rst || clear) begin
            for (int i = 0; i < ENTRIES; i++) m_slot[i].busy = 1'b0;
            m_work = 1'b0; m_opo = '0; m_opt = '0; m_opc = '0;
            m_wtag = '0; m_wname = '0; m_addr = '0;
        end else begin
            sel = -1;
            fr  = -1;
            for (int i = 0; i < ENTRIES; i++) begin
                if (sel < 0 && m_slot[i].busy && m_slot[i].to == '0 && m_slot[i].tt == '0) sel = i;
                if (fr < 0 && !m_slot[i].busy) fr = i;
            end
            m_work = (sel >= 0);
            if (sel >= 0) begin
                m_opo   = m_slot[sel].vo;
                m_opt   = m_slot[sel].vt;
                m_opc   = m_slot[sel].op;
                m_wtag  = m_slot[sel].wt;
                m_wname = m_slot[sel].wn;
                m_addr  = m_slot[sel].ad;
                m_slot[sel].busy = 1'b0;
            end
            for (int i = 0; i < ENTRIES; i++) begin
                if (m_slot[i].busy) begin
                    if (cdb_lookup(m_slot[i].to, d)) begin m_slot[i].vo = d; m_slot[i].to = '0; end
                    if (cdb_lookup(m_slot[i].tt, d)) begin m_slot[i].vt = d; m_slot[i].tt = '0; end
                end
            end
            if (dispEn && fr >= 0) begin
                ns.busy = 1'b1;
                ns.op = dispOp; ns.wt = dispWrtTag; ns.wn = dispWrtName; ns.ad = dispAddr;
                ns.vo = dispDataO; ns.to = dispTagO;
                ns.vt = dispDataT; ns.tt = dispTagT;
                if (cdb_lookup(dispTagO, d)) begin ns.vo = d; ns.to = '0; end
                if (cdb_lookup(dispTagT, d)) begin ns.vt = d; ns.tt = '0; end
                m_slot[fr] = ns;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("rsFull",    64'(rsFull),    64'(m_full()));
            check("ALUworkEn", 64'(ALUworkEn), 64'(m_work));
            check("operandO",  64'(operandO),  64'(m_opo));
            check("operandT",  64'(operandT),  64'(m_opt));
            check("opCode",    64'(opCode),    64'(m_opc));
            check("wrtTag",    64'(wrtTag),    64'(m_wtag));
            check("wrtName",   64'(wrtName),   64'(m_wname));
            check("instAddr",  64'(instAddr),  64'(m_addr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        dispEn   = 1'b0;
        aluCdbEn = 1'b0;
        lsCdbEn  = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic set_disp(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] d_o,
                            input logic [DATA_W-1:0] d_t, input logic [TAG_W-1:0] t_o,
                            input logic [TAG_W-1:0] t_t, input logic [TAG_W-1:0] wt,
                            input logic [NAME_W-1:0] wn, input logic [ADDR_W-1:0] ad);
        dispEn = 1'b1; dispOp = op; dispDataO = d_o; dispDataT = d_t;
        dispTagO = t_o; dispTagT = t_t; dispWrtTag = wt; dispWrtName = wn; dispAddr = ad;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst = 1'b1; clear = 1'b0; dispEn = 1'b0; dispOp = '0;
        dispDataO = '0; dispDataT = '0; dispTagO = '0; dispTagT = '0;
        dispWrtTag = '0; dispWrtName = '0; dispAddr = '0;
        aluCdbEn = 1'b0; aluCdbTag = '0; aluCdbData = '0;
        lsCdbEn = 1'b0; lsCdbTag = '0; lsCdbData = '0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("idle_rsFull", 64'(rsFull), 64'd0);
            check("idle_workEn", 64'(ALUworkEn), 64'd0);
        end

        // ADD 5,7 -> issue exactly two cycles later for one cycle
        set_disp(6'd1, 32'd5, 32'd7, 4'd0, 4'd0, 4'd3, 5'd1, 32'h100);
        cyc();
        idle_inputs();
        check("add_lat1_workEn", 64'(ALUworkEn), 64'd0);
        cyc();
        check("add_workEn", 64'(ALUworkEn), 64'd1);
        check("add_opO", 64'(operandO), 64'd5);
        check("add_opT", 64'(operandT), 64'd7);
        check("add_wrtTag", 64'(wrtTag), 64'd3);
        cyc();
        check("add_strobe_end", 64'(ALUworkEn), 64'd0);

        // Dependency wakeup through the LSU bus
        set_disp(6'd2, 32'h11, 32'hbeef, 4'd0, 4'd6, 4'd4, 5'd2, 32'h104);
        cyc();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("dep_wait_workEn", 64'(ALUworkEn), 64'd0);
        end
        lsCdbEn = 1'b1; lsCdbTag = 4'd6; lsCdbData = 32'h1234;
        cyc();
        idle_inputs();
        check("dep_lat1_workEn", 64'(ALUworkEn), 64'd0);
        cyc();
        check("dep_workEn", 64'(ALUworkEn), 64'd1);
        check("dep_opT", 64'(operandT), 64'h1234);
        check("dep_opO", 64'(operandO), 64'h11);
        cyc();

        // Dispatch forwarding from the ALU bus
        aluCdbEn = 1'b1; aluCdbTag = 4'd2; aluCdbData = 32'd9;
        set_disp(6'd3, 32'hdead, 32'h22, 4'd2, 4'd0, 4'd5, 5'd3, 32'h108);
        cyc();
        idle_inputs();
        cyc();
        check("fwd_workEn", 64'(ALUworkEn), 64'd1);
        check("fwd_opO", 64'(operandO), 64'd9);
        check("fwd_opT", 64'(operandT), 64'h22);
        cyc();

        // Fill all slots, ignored 9th dispatch, then wake all eight
        for (int i = 0; i < ENTRIES; i++) begin
            set_disp(6'd4, DATA_W'(i), DATA_W'(i + 100), 4'd5, 4'd0, TAG_W'(i + 1),
                     NAME_W'(i), ADDR_W'(32'h200 + 4 * i));
            cyc();
        end
        idle_inputs();
        check("fill_rsFull", 64'(rsFull), 64'd1);
        set_disp(6'd5, 32'h99, 32'h99, 4'd0, 4'd0, 4'd15, 5'd31, 32'hfff0);
        cyc();
        idle_inputs();
        check("full_ignore_rsFull", 64'(rsFull), 64'd1);
        check("full_ignore_workEn", 64'(ALUworkEn), 64'd0);
        aluCdbEn = 1'b1; aluCdbTag = 4'd5; aluCdbData = 32'h55;
        cyc();
        idle_inputs();
        check("fill_wake_workEn", 64'(ALUworkEn), 64'd0);
        for (int i = 0; i < ENTRIES; i++) begin
            cyc();
            check("fill_drain_workEn", 64'(ALUworkEn), 64'd1);
            check("fill_drain_order", 64'(wrtName), 64'(i));
            check("fill_drain_opO", 64'(operandO), 64'h55);
        end
        check("fill_after_rsFull", 64'(rsFull), 64'd0);
        cyc();
        check("fill_after_workEn", 64'(ALUworkEn), 64'd0);

        // Priority: slots 1 and 4 wake together
        set_disp(6'd6, 32'd0, 32'd0, 4'd7, 4'd0, 4'd1, 5'd10, 32'h300); cyc();
        set_disp(6'd6, 32'd1, 32'd1, 4'd0, 4'd8, 4'd2, 5'd11, 32'h304); cyc();
        set_disp(6'd6, 32'd2, 32'd2, 4'd7, 4'd0, 4'd3, 5'd12, 32'h308); cyc();
        set_disp(6'd6, 32'd3, 32'd3, 4'd7, 4'd0, 4'd4, 5'd13, 32'h30c); cyc();
        set_disp(6'd6, 32'd4, 32'd4, 4'd8, 4'd0, 4'd5, 5'd14, 32'h310); cyc();
        idle_inputs();
        aluCdbEn = 1'b1; aluCdbTag = 4'd8; aluCdbData = 32'h88;
        cyc();
        idle_inputs();
        cyc();
        check("prio_first", 64'(wrtName), 64'd11);
        check("prio_first_opT", 64'(operandT), 64'h88);
        cyc();
        check("prio_second", 64'(wrtName), 64'd14);
        check("prio_second_opO", 64'(operandO), 64'h88);
        cyc();
        check("prio_gap_workEn", 64'(ALUworkEn), 64'd0);
        lsCdbEn = 1'b1; lsCdbTag = 4'd7; lsCdbData = 32'h77;
        cyc();
        idle_inputs();
        cyc(); check("prio_rest0", 64'(wrtName), 64'd10);
        cyc(); check("prio_rest1", 64'(wrtName), 64'd12);
        cyc(); check("prio_rest2", 64'(wrtName), 64'd13);
        cyc(); check("prio_done_workEn", 64'(ALUworkEn), 64'd0);

        // Flush on the first issue cycle
        for (int i = 0; i < 3; i++) begin
            set_disp(6'd7, DATA_W'(i + 1), 32'd0, 4'd9, 4'd0, TAG_W'(i + 1),
                     NAME_W'(20 + i), 32'h400);
            cyc();
        end
        idle_inputs();
        aluCdbEn = 1'b1; aluCdbTag = 4'd9; aluCdbData = 32'h90;
        cyc();
        idle_inputs();
        cyc();
        check("flush_first_issue", 64'(ALUworkEn), 64'd1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("flush_workEn", 64'(ALUworkEn), 64'd0);
        check("flush_rsFull", 64'(rsFull), 64'd0);
        check("flush_opO_zero", 64'(operandO), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("flush_quiet", 64'(ALUworkEn), 64'd0);
        end
        set_disp(6'd8, 32'h42, 32'h43, 4'd0, 4'd0, 4'd6, 5'd7, 32'h500);
        cyc();
        idle_inputs();
        cyc();
        check("post_flush_workEn", 64'(ALUworkEn), 64'd1);
        check("post_flush_opO", 64'(operandO), 64'h42);
        cyc();

        // Randomized traffic checked against the model
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            if ($urandom_range(0, 99) < 60 && !rsFull) begin
                set_disp(OP_W'($urandom), $urandom, $urandom,
                         $urandom_range(0, 1) ? 4'd0 : TAG_W'($urandom_range(1, 15)),
                         $urandom_range(0, 1) ? 4'd0 : TAG_W'($urandom_range(1, 15)),
                         TAG_W'($urandom), NAME_W'($urandom), $urandom);
            end
            aluCdbEn   = 1'($urandom_range(0, 1));
            aluCdbTag  = TAG_W'($urandom_range(1, 15));
            aluCdbData = $urandom;
            lsCdbEn    = 1'($urandom_range(0, 1));
            lsCdbTag   = TAG_W'($urandom_range(1, 15));
            lsCdbData  = $urandom;
            if (aluCdbEn && lsCdbEn && aluCdbTag == lsCdbTag) lsCdbEn = 1'b0;
            if ($urandom_range(0, 99) == 0) clear = 1'b1;
            cyc();
        end
        idle_inputs();
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
